ddr_arbiter: RTL and testbench

Two-port round-robin arbiter and block sequencer in front of `ddr_ctrl`, in the `ui_clk` domain. Each requester (port 0 = D-cache, port 1 = I-cache) issues one 256-bit block read or write. The arbiter grants one port at a time. Each block is split into two 128-bit `ddr_ctrl` operations, low half then high half. Read data is returned in one shared register, and a per-port done pulse signals completion.

---
 rtl/ddr_arbiter_if.sv | 47 ++++
 rtl/ddr_arbiter.sv | 135 +++++++++++++
 tb/tb_ddr_arbiter.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr_arbiter_if.sv
// ddr_arbiter bundle: two block requesters plus the ddr_ctrl side.
// The arbiter takes the slave view; requesters/ddr_ctrl take master.
interface ddr_arbiter_if #(
  parameter int CNT_W = 16
);
  logic             req0;
  logic             req1;
  logic             write0;
  logic             write1;
  logic [29:0]      addr0;
  logic [29:0]      addr1;
  logic [255:0]     wdata0;
  logic [255:0]     wdata1;
  logic             done0;
  logic             done1;
  logic [255:0]     rdata;
  logic             ram_en;
  logic             ram_write;
  logic [29:0]      ram_addr;
  logic [255:0]     data_to_ram;
  logic             ram_rdy;
  logic [255:0]     block_out;
  logic             grant;
  logic             busy;
  logic [CNT_W-1:0] xfers0;
  logic [CNT_W-1:0] xfers1;

  modport slave (
    input  req0, req1, write0, write1,
    input  addr0, addr1, wdata0, wdata1,
    output done0, done1, rdata,
    output ram_en, ram_write, ram_addr,
    output data_to_ram,
    input  ram_rdy, block_out,
    output grant, busy, xfers0, xfers1
  );

  modport master (
    output req0, req1, write0, write1,
    output addr0, addr1, wdata0, wdata1,
    input  done0, done1, rdata,
    input  ram_en, ram_write, ram_addr,
    input  data_to_ram,
    output ram_rdy, block_out,
    input  grant, busy, xfers0, xfers1
  );
endinterface

// File: rtl/ddr_arbiter.sv
// Two-port round-robin arbiter; splits each 256-bit block
// into low/high 128-bit ddr_ctrl operations.
module ddr_arbiter #(
  parameter int CNT_W = 16
) (
  input logic        clk,
  input logic        rst,
  ddr_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    LO_ISSUE,
    LO_WAIT,
    HI_ISSUE,
    HI_WAIT,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic             cur_write_q, cur_write_d;
  logic [26:0]      cur_addr_q, cur_addr_d;
  logic [255:0]     cur_wdata_q, cur_wdata_d;
  logic [255:0]     rbuf_q, rbuf_d;
  logic [255:0]     rdata_q, rdata_d;
  logic [CNT_W-1:0] xfers0_q, xfers0_d;
  logic [CNT_W-1:0] xfers1_q, xfers1_d;
  logic             win;
  logic             ram_en;
  logic             hi_half;
  logic             in_done;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    cur_write_d  = cur_write_q;
    cur_addr_d   = cur_addr_q;
    cur_wdata_d  = cur_wdata_q;
    rbuf_d       = rbuf_q;
    rdata_d      = rdata_q;
    xfers0_d     = xfers0_q;
    xfers1_d     = xfers1_q;
    // on a tie the port not served last wins
    win = (bus.req0 & bus.req1) ?
          ~last_grant_q : bus.req1;
    unique case (state_q)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          grant_d     = win;
          cur_write_d = win ? bus.write1 : bus.write0;
          cur_addr_d  = win ? bus.addr1[29:3]
                            : bus.addr0[29:3];
          cur_wdata_d = win ? bus.wdata1 : bus.wdata0;
          state_d     = LO_ISSUE;
        end
      end
      LO_ISSUE: state_d = LO_WAIT;
      LO_WAIT: begin
        if (bus.ram_rdy) begin
          if (!cur_write_q)
            rbuf_d[127:0] = bus.block_out[127:0];
          state_d = HI_ISSUE;
        end
      end
      HI_ISSUE: state_d = HI_WAIT;
      HI_WAIT: begin
        if (bus.ram_rdy) begin
          if (!cur_write_q)
            rbuf_d[255:128] = bus.block_out[255:128];
          state_d = DONE;
        end
      end
      DONE: begin
        last_grant_d = grant_q;
        if (!cur_write_q) rdata_d = rbuf_q;
        if (grant_q) xfers1_d = xfers1_q + 1'b1;
        else         xfers0_d = xfers0_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cur_write_q  <= 1'b0;
      cur_addr_q   <= '0;
      cur_wdata_q  <= '0;
      rbuf_q       <= '0;
      rdata_q      <= '0;
      xfers0_q     <= '0;
      xfers1_q     <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cur_write_q  <= cur_write_d;
      cur_addr_q   <= cur_addr_d;
      cur_wdata_q  <= cur_wdata_d;
      rbuf_q       <= rbuf_d;
      rdata_q      <= rdata_d;
      xfers0_q     <= xfers0_d;
      xfers1_q     <= xfers1_d;
    end
  end

  assign ram_en  = (state_q == LO_ISSUE) |
                   (state_q == LO_WAIT)  |
                   (state_q == HI_ISSUE) |
                   (state_q == HI_WAIT);
  assign hi_half = (state_q == HI_ISSUE) |
                   (state_q == HI_WAIT);
  assign in_done = (state_q == DONE);

  assign bus.ram_en      = ram_en;
  assign bus.ram_write   = ram_en & cur_write_q;
  assign bus.ram_addr    = {cur_addr_q, hi_half, 2'b00};
  // cur_wdata only reloads in IDLE, so it holds between blocks
  assign bus.data_to_ram = cur_wdata_q;
  assign bus.done0       = in_done & ~grant_q;
  assign bus.done1       = in_done & grant_q;
  assign bus.rdata       = (in_done & ~cur_write_q) ?
                           rbuf_q : rdata_q;
  assign bus.grant       = grant_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.xfers0      = xfers0_q;
  assign bus.xfers1      = xfers1_q;

endmodule

// File: tb/tb_ddr_arbiter.sv
// Bench for ddr_arbiter: ddr_ctrl model, requesters and a
// transaction-level scoreboard compared every cycle.
module tb_ddr_arbiter;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ddr_arbiter_if #(.CNT_W(CNT_W)) bus();
  ddr_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic         req_v   [2];
  logic         write_v [2];
  logic [29:0]  addr_v  [2];
  logic [255:0] wdata_v [2];
  logic         ram_rdy_v;
  logic [255:0] block_out_v;

  assign bus.req0      = req_v[0];
  assign bus.req1      = req_v[1];
  assign bus.write0    = write_v[0];
  assign bus.write1    = write_v[1];
  assign bus.addr0     = addr_v[0];
  assign bus.addr1     = addr_v[1];
  assign bus.wdata0    = wdata_v[0];
  assign bus.wdata1    = wdata_v[1];
  assign bus.ram_rdy   = ram_rdy_v;
  assign bus.block_out = block_out_v;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm,
                     input logic [255:0] act,
                     input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else if (n_checks - n_pass < 40)
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // ---------------- ddr_ctrl model ----------------
  logic [127:0] mem [logic [29:0]];
  int lat_min = 1;
  int lat_max = 4;
  bit spur_en = 1'b0;

  function automatic logic [127:0] rd(input logic [29:0] a);
    if (mem.exists(a)) return mem[a];
    return {4{a, 2'b10}};
  endfunction

  initial begin
    bit           pend;
    bit           have_last;
    int           cnt;
    logic [30:0]  key;
    logic [30:0]  last_key;
    logic [30:0]  op_key;
    logic [255:0] op_data;
    logic [255:0] r;
    logic         rs;
    pend = 0; have_last = 0; cnt = 0;
    last_key = '0; op_key = '0; op_data = '0;
    ram_rdy_v = 1'b0;
    block_out_v = '0;
    forever begin
      @(posedge clk);
      rs = rst;
      #2;
      ram_rdy_v = 1'b0;
      r = rnd256();
      block_out_v = r;
      if (!rs) begin
        pend = 0;
        have_last = 0;
      end else begin
        key = {bus.ram_write, bus.ram_addr};
        if (pend) begin
          if (cnt <= 1) begin
            ram_rdy_v = 1'b1;
            pend = 0;
            have_last = 1;
            last_key = op_key;
            if (op_key[30]) begin
              mem[op_key[29:0]] = op_key[2] ?
                op_data[255:128] : op_data[127:0];
            end else if (op_key[2]) begin
              block_out_v = {rd(op_key[29:0]), r[127:0]};
            end else begin
              block_out_v = {r[255:128], rd(op_key[29:0])};
            end
          end else begin
            cnt--;
          end
        end else if (bus.ram_en &&
                     (!have_last || key != last_key)) begin
          pend = 1;
          cnt = $urandom_range(lat_max, lat_min);
          op_key = key;
          op_data = bus.data_to_ram;
          // a ready seen before the op's first wait cycle is noise
          ram_rdy_v = spur_en & $urandom_range(0, 1);
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  bit           cmp_en = 1'b0;
  int           m_phase = 0;
  bit           m_first = 0;
  bit           m_port = 0;
  bit           m_write = 0;
  logic [26:0]  m_base = '0;
  logic [255:0] m_wdata = '0;
  logic [255:0] m_exp = '0;
  logic [255:0] m_rdata = '0;
  bit           m_grant = 0;
  bit           m_lg = 1;
  logic [15:0]  m_x [2] = '{16'd0, 16'd0};

  logic [29:0]  addr_log [$];
  int           done_log [$];
  int           en_cycles = 0;
  int           wr_cycles = 0;
  int           done_cyc = 0;

  initial begin
    bit           prev_en;
    bit           en_exp;
    bit           p;
    logic [29:0]  last_a;
    prev_en = 0;
    last_a = '0;
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        en_exp = (m_phase == 1 || m_phase == 2);
        chk("ram_en", bus.ram_en, en_exp);
        chk("busy", bus.busy, m_phase != 0);
        chk("grant", bus.grant, m_grant);
        chk("done0", bus.done0, m_phase == 3 && !m_port);
        chk("done1", bus.done1, m_phase == 3 && m_port);
        chk("xfers0", bus.xfers0, m_x[0]);
        chk("xfers1", bus.xfers1, m_x[1]);
        if (en_exp) begin
          chk("ram_addr", bus.ram_addr,
              {m_base, m_phase == 2, 2'b00});
          chk("ram_write", bus.ram_write, m_write);
          chk("data_to_ram", bus.data_to_ram, m_wdata);
        end else begin
          chk("ram_write_off", bus.ram_write, 1'b0);
        end
        if (m_phase == 3 && !m_write)
          chk("rdata_at_done", bus.rdata, m_exp);
        else
          chk("rdata_hold", bus.rdata, m_rdata);

        if (bus.ram_en) begin
          en_cycles++;
          if (bus.ram_write) wr_cycles++;
          if (!prev_en || bus.ram_addr != last_a) begin
            addr_log.push_back(bus.ram_addr);
            last_a = bus.ram_addr;
          end
        end
        prev_en = bus.ram_en;
        if (bus.done0) done_log.push_back(0);
        if (bus.done1) done_log.push_back(1);
        if (bus.done0 || bus.done1) done_cyc = cyc;

        if (!rst) begin
          m_phase = 0;
          m_grant = 0;
          m_lg = 1;
          m_x[0] = '0;
          m_x[1] = '0;
          m_rdata = '0;
        end else begin
          case (m_phase)
            0: if (req_v[0] || req_v[1]) begin
              p = (req_v[0] && req_v[1]) ? !m_lg : req_v[1];
              m_port  = p;
              m_grant = p;
              m_write = write_v[p];
              m_base  = addr_v[p][29:3];
              m_wdata = wdata_v[p];
              m_exp   = {rd({addr_v[p][29:3], 3'b100}),
                         rd({addr_v[p][29:3], 3'b000})};
              m_phase = 1;
              m_first = 1;
            end
            1, 2: begin
              if (m_first) m_first = 0;
              else if (bus.ram_rdy) begin
                m_phase = m_phase + 1;
                m_first = (m_phase == 2);
              end
            end
            default: begin
              m_x[m_port] = m_x[m_port] + 16'd1;
              m_lg = m_port;
              if (!m_write) m_rdata = m_exp;
              m_phase = 0;
            end
          endcase
        end
      end
    end
  end

  // ---------------- requesters ----------------
  task automatic do_xfer(input int p, input logic w,
                         input logic [29:0] a,
                         input logic [255:0] d);
    bit seen;
    write_v[p] = w;
    addr_v[p]  = a;
    wdata_v[p] = d;
    req_v[p]   = 1'b1;
    seen = 0;
    for (int t = 0; t < 300 && !seen; t++) begin
      @(negedge clk);
      seen = (p == 0) ? bus.done0 : bus.done1;
    end
    if (!seen) begin
      n_checks++;
      $display("FAIL timeout_port%0d: no done in 300 cycles, required done", p);
    end
    @(posedge clk);
    #1;
    req_v[p] = 1'b0;
  endtask

  function automatic logic [29:0] rand_addr();
    return 30'h1000 + 30'($urandom_range(0, 15) << 3)
                    + 30'($urandom_range(0, 7));
  endfunction

  task automatic rand_port(input int p, input int n);
    repeat (n) begin
      repeat ($urandom_range(1, 4)) begin
        @(posedge clk);
        #1;
      end
      do_xfer(p, 1'($urandom_range(0, 1)),
              rand_addr(), rnd256());
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  localparam logic [127:0] PAT_A = {4{32'hAAAA_AAAA}};
  localparam logic [127:0] PAT_B = {4{32'hBBBB_BBBB}};
  localparam logic [255:0] WPAT  = {{4{32'h1111_2222}},
                                    {4{32'h3333_4444}}};

  initial begin
    int n0;
    int nd;
    for (int i = 0; i < 2; i++) begin
      req_v[i] = 1'b1;
      write_v[i] = 1'b0;
      addr_v[i] = '0;
      wdata_v[i] = '0;
    end
    rst = 1'b0;

    // reset with both ports requesting
    @(posedge clk);
    #1 cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ram_en", bus.ram_en, 1'b0);
    chk("rst_done0", bus.done0, 1'b0);
    chk("rst_done1", bus.done1, 1'b0);
    chk("rst_xfers0", bus.xfers0, 16'd0);
    chk("rst_xfers1", bus.xfers1, 16'd0);
    chk("rst_busy", bus.busy, 1'b0);
    @(posedge clk);
    #1;
    req_v[0] = 1'b0;
    req_v[1] = 1'b0;
    rst = 1'b1;
    idle(2);

    // single read, 4-cycle latency
    lat_min = 4; lat_max = 4; spur_en = 0;
    mem[30'h100] = PAT_A;
    mem[30'h104] = PAT_B;
    addr_log.delete(); done_log.delete();
    en_cycles = 0; wr_cycles = 0;
    do_xfer(0, 1'b0, 30'h100, '0);
    @(negedge clk);
    chk("rd_naddr", addr_log.size(), 2);
    if (addr_log.size() == 2) begin
      chk("rd_addr_lo", addr_log[0], 30'h100);
      chk("rd_addr_hi", addr_log[1], 30'h104);
    end
    chk("rd_write", wr_cycles, 0);
    chk("rd_ndone", done_log.size(), 1);
    chk("rd_rdata", bus.rdata, {PAT_B, PAT_A});
    chk("rd_xfers0", bus.xfers0, 16'd1);
    idle(2);

    // single write from port 1
    addr_log.delete(); done_log.delete();
    en_cycles = 0; wr_cycles = 0;
    do_xfer(1, 1'b1, 30'h2008, WPAT);
    @(negedge clk);
    chk("wr_naddr", addr_log.size(), 2);
    if (addr_log.size() == 2) begin
      chk("wr_addr_lo", addr_log[0], 30'h2008);
      chk("wr_addr_hi", addr_log[1], 30'h200C);
    end
    chk("wr_all_write", wr_cycles, en_cycles);
    chk("wr_mem_lo", rd(30'h2008), WPAT[127:0]);
    chk("wr_mem_hi", rd(30'h200C), WPAT[255:128]);
    chk("wr_ndone", done_log.size(), 1);
    if (done_log.size() == 1) chk("wr_port", done_log[0], 1);
    chk("wr_rdata_kept", bus.rdata, {PAT_B, PAT_A});
    chk("wr_xfers1", bus.xfers1, 16'd1);
    idle(2);

    // contention: strict alternation starting at port 0
    lat_min = 1; lat_max = 4; spur_en = 1;
    done_log.delete();
    fork
      begin
        repeat (4) begin
          do_xfer(0, 1'b0, rand_addr(), '0);
          idle(1);
        end
      end
      begin
        repeat (4) begin
          do_xfer(1, 1'b1, rand_addr(), rnd256());
          idle(1);
        end
      end
    join
    chk("cont_ndone", done_log.size(), 8);
    for (int i = 0; i < 8 && i < done_log.size(); i++)
      chk($sformatf("cont_order%0d", i), done_log[i], i % 2);
    @(negedge clk);
    chk("cont_xfers0", bus.xfers0, 16'd5);
    chk("cont_xfers1", bus.xfers1, 16'd5);
    idle(2);

    // minimum latency: done 5 cycles after the sample cycle
    lat_min = 1; lat_max = 1; spur_en = 0;
    idle(2);
    n0 = cyc;
    do_xfer(0, 1'b1, 30'h40, rnd256());
    chk("min_latency", done_cyc - n0, 5);
    idle(2);

    // reset during HI_WAIT
    lat_min = 4; lat_max = 4;
    mem[30'h300] = {4{32'h0C0C_0C0C}};
    mem[30'h304] = {4{32'hD0D0_D0D0}};
    nd = done_log.size();
    write_v[0] = 1'b0;
    addr_v[0] = 30'h300;
    req_v[0] = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (bus.ram_en && bus.ram_addr[2]) break;
    end
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_v[0] = 1'b0;
    @(negedge clk);
    chk("mid_ram_en", bus.ram_en, 1'b0);
    chk("mid_busy", bus.busy, 1'b0);
    chk("mid_xfers0", bus.xfers0, 16'd0);
    idle(6);
    chk("mid_no_done", done_log.size(), nd);
    do_xfer(1, 1'b0, 30'h300, '0);
    @(negedge clk);
    chk("mid_after_xfers1", bus.xfers1, 16'd1);
    chk("mid_after_rdata", bus.rdata,
        {{4{32'hD0D0_D0D0}}, {4{32'h0C0C_0C0C}}});
    idle(2);

    // randomized traffic
    lat_min = 1; lat_max = 4; spur_en = 1;
    fork
      rand_port(0, 150);
      rand_port(1, 150);
    join
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
